// File: rtl/reg_hazard_scoreboard.sv
// ============================================================================
// Module   : reg_hazard_scoreboard
// Purpose  : ID-stage register scoreboard with per-register write-back
//            countdowns, per-port RAW hazard flags, stall/issue strobes and
//            occupancy/stall statistics. `SCOREBOARD_FWD_EN selects
//            EX/MEM-forwarding hazard threshold.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module reg_hazard_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_READ       = 2,
  parameter int CNT_WIDTH      = 3,
  parameter int ALU_LATENCY    = 1,
  parameter int LOAD_LATENCY   = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_valid,
  input  logic [NUM_READ-1:0]                rd_en,
  input  logic [NUM_READ*REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic                               wr_en,
  input  logic [REG_ADDR_WIDTH-1:0]          wr_addr,
  input  logic                               wr_is_load,
  input  logic                               flush,
  output logic [NUM_READ-1:0]                hazard,
  output logic                               stall,
  output logic                               issue_fire,
  output logic [REG_ADDR_WIDTH:0]            busy_count,
  output logic [15:0]                        stall_cycles
);

  localparam int c_NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] c_ALU_LAT  = CNT_WIDTH'(ALU_LATENCY);
  localparam logic [CNT_WIDTH-1:0] c_LOAD_LAT = CNT_WIDTH'(LOAD_LATENCY);
`ifdef SCOREBOARD_FWD_EN
  // A counter of 1 means the value sits in EX/MEM and can be bypassed.
  localparam logic [CNT_WIDTH-1:0] c_THRESH = CNT_WIDTH'(2);
`else
  localparam logic [CNT_WIDTH-1:0] c_THRESH = CNT_WIDTH'(1);
`endif

  logic [CNT_WIDTH-1:0]      r_cnt      [c_NUM_REGS];
  logic [CNT_WIDTH-1:0]      w_cnt_next [c_NUM_REGS];
  logic [CNT_WIDTH-1:0]      w_wr_lat;
  logic [REG_ADDR_WIDTH:0]   w_busy_next;
  logic [REG_ADDR_WIDTH:0]   r_busy_count;
  logic [15:0]               r_stall_cycles;

  for (genvar i = 0; i < NUM_READ; i++) begin : g_hazard
    logic [REG_ADDR_WIDTH-1:0] w_addr;
    assign w_addr    = rd_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign hazard[i] = rd_en[i] && (w_addr != '0) && (r_cnt[w_addr] >= c_THRESH);
  end

  assign stall        = issue_valid && (|hazard);
  assign issue_fire   = issue_valid && !stall && !flush;
  assign w_wr_lat     = wr_is_load ? c_LOAD_LAT : c_ALU_LAT;
  assign busy_count   = r_busy_count;
  assign stall_cycles = r_stall_cycles;

  // New writes take the max with the decayed count so a younger short-latency
  // write never hides an older long-latency one (WAW).
  always_comb begin
    w_busy_next = '0;
    for (int r = 0; r < c_NUM_REGS; r++) begin
      w_cnt_next[r] = (r_cnt[r] != '0) ? (r_cnt[r] - CNT_WIDTH'(1)) : '0;
      if (flush || (r == 0)) begin
        w_cnt_next[r] = '0;
      end else if (issue_fire && wr_en && (wr_addr == REG_ADDR_WIDTH'(r)) &&
                   (w_cnt_next[r] < w_wr_lat)) begin
        w_cnt_next[r] = w_wr_lat;
      end
      if (w_cnt_next[r] != '0) begin
        w_busy_next = w_busy_next + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < c_NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
      r_busy_count   <= '0;
      r_stall_cycles <= '0;
    end else begin
      for (int r = 0; r < c_NUM_REGS; r++) begin
        r_cnt[r] <= w_cnt_next[r];
      end
      r_busy_count <= w_busy_next;
      if (stall && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_reg_hazard_scoreboard
// Purpose  : Scoreboard bench for reg_hazard_scoreboard (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_reg_hazard_scoreboard;

  localparam int AW  = 5;
  localparam int NR  = 3;
  localparam int ALU = 1;
  localparam int LD  = 7;
`ifdef SCOREBOARD_FWD_EN
  localparam int THR = 2;
`else
  localparam int THR = 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid;
  logic [NR-1:0]   rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic            wr_is_load;
  logic            flush;
  logic [NR-1:0]   hazard;
  logic            stall;
  logic            issue_fire;
  logic [AW:0]     busy_count;
  logic [15:0]     stall_cycles;

  reg_hazard_scoreboard #(
    .REG_ADDR_WIDTH(AW), .NUM_READ(NR), .CNT_WIDTH(3),
    .ALU_LATENCY(ALU), .LOAD_LATENCY(LD)
  ) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .rd_en(rd_en),
    .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_is_load(wr_is_load), .flush(flush), .hazard(hazard), .stall(stall),
    .issue_fire(issue_fire), .busy_count(busy_count),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR-1:0] hz;
    logic          st;
    logic          fi;
    logic [AW:0]   bc;
    logic [15:0]   sc;
    logic          chk;
    logic [31:0]   cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: each register remembers the cycle at which its pending
  // write-back completes; remaining latency is derived from the cycle number.
  int          ready_at [2**AW];
  int          k = 0;
  logic [15:0] m_sc = '0;

  function automatic int rem(int r);
    return (ready_at[r] > k) ? (ready_at[r] - k) : 0;
  endfunction

  function automatic logic [NR*AW-1:0] pk(int a0, int a1, int a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  task automatic drive(input logic iv, input logic [NR-1:0] re,
                       input logic [NR*AW-1:0] ra, input logic we,
                       input int wa, input logic ld, input logic fl,
                       input logic rv, input logic chk, output logic fired);
    exp_t e;
    int   a;
    int   nb;
    @(negedge clk);
    rst = rv; issue_valid = iv; rd_en = re; rd_addr = ra; wr_en = we;
    wr_addr = AW'(wa); wr_is_load = ld; flush = fl;
    if (!rv) begin
      for (int r = 0; r < 2**AW; r++) ready_at[r] = 0;
      m_sc = '0;
    end
    e.hz = '0;
    for (int i = 0; i < NR; i++) begin
      a = int'(ra[i*AW +: AW]);
      if (re[i] && a != 0 && rem(a) >= THR) e.hz[i] = 1'b1;
    end
    e.st = iv && (e.hz != '0);
    e.fi = iv && !e.st && !fl;
    nb = 0;
    for (int r = 1; r < 2**AW; r++) if (rem(r) > 0) nb++;
    e.bc  = (AW+1)'(nb);
    e.sc  = m_sc;
    e.chk = chk;
    e.cyc = 32'(k);
    q.push_back(e);
    fired = e.fi;
    if (rv) begin
      if (fl) begin
        for (int r = 0; r < 2**AW; r++) ready_at[r] = 0;
      end else if (e.fi && we && wa != 0) begin
        if (ready_at[wa] < k + 1 + (ld ? LD : ALU)) ready_at[wa] = k + 1 + (ld ? LD : ALU);
      end
      if (e.st && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
    end
    k++;
  endtask

  // Hold one instruction in ID until it issues (bounded).
  task automatic hold(input logic [NR-1:0] re, input logic [NR*AW-1:0] ra,
                      input logic we, input int wa, input logic ld);
    logic f;
    for (int n = 0; n < 20; n++) begin
      drive(1'b1, re, ra, we, wa, ld, 1'b0, 1'b1, 1'b1, f);
      if (f) break;
    end
  endtask

  task automatic idle(input int n);
    logic f;
    for (int i = 0; i < n; i++)
      drive(1'b0, '0, '0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, f);
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        checks++;
        if (hazard !== e.hz || stall !== e.st || issue_fire !== e.fi ||
            busy_count !== e.bc || stall_cycles !== e.sc) begin
          errors++;
          $display("FAIL cycle%0d: got hz=%b st=%b fi=%b bc=%0d sc=%0d exp hz=%b st=%b fi=%b bc=%0d sc=%0d",
                   e.cyc, hazard, stall, issue_fire, busy_count, stall_cycles,
                   e.hz, e.st, e.fi, e.bc, e.sc);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic f;
    int   n;
    int   extra;
    for (int r = 0; r < 2**AW; r++) ready_at[r] = 0;
    rst = 1'b0; issue_valid = 0; rd_en = '0; rd_addr = '0; wr_en = 0;
    wr_addr = '0; wr_is_load = 0; flush = 0;

    // Reset state, with reads requested
    drive(1'b1, 3'b111, pk(1, 2, 3), 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, f);
    drive(1'b0, '0, '0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, f);
    idle(1);

    // ALU RAW on $8
    hold(3'b000, '0, 1'b1, 8, 1'b0);
    hold(3'b001, pk(8, 0, 0), 1'b0, 0, 1'b0);
    idle(2);

    // Load-use on $9, port 1
    hold(3'b000, '0, 1'b1, 9, 1'b1);
    hold(3'b010, pk(0, 9, 0), 1'b0, 0, 1'b0);
    idle(2);

    // WAW: load then ALU write to $10, then consumer
    hold(3'b000, '0, 1'b1, 10, 1'b1);
    hold(3'b000, '0, 1'b1, 10, 1'b0);
    hold(3'b100, pk(0, 0, 10), 1'b0, 0, 1'b0);

    // $0 read/write
    hold(3'b111, pk(0, 0, 0), 1'b1, 0, 1'b1);
    idle(2);

    // Read-and-write same register does not self-stall
    hold(3'b001, pk(11, 0, 0), 1'b1, 11, 1'b1);
    idle(1);

    // Flush with three busy registers
    hold(3'b000, '0, 1'b1, 12, 1'b1);
    hold(3'b000, '0, 1'b1, 13, 1'b1);
    hold(3'b000, '0, 1'b1, 14, 1'b1);
    drive(1'b1, 3'b001, pk(12, 0, 0), 1'b1, 15, 1'b1, 1'b1, 1'b1, 1'b1, f);
    drive(1'b1, 3'b111, pk(12, 13, 14), 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, f);
    idle(1);

    // All ports on one busy register
    hold(3'b000, '0, 1'b1, 16, 1'b1);
    drive(1'b1, 3'b111, pk(16, 16, 16), 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, f);

    // Mid-run asynchronous reset with counters loaded
    hold(3'b000, '0, 1'b1, 17, 1'b1);
    drive(1'b1, 3'b001, pk(17, 0, 0), 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, f);
    drive(1'b1, 3'b001, pk(17, 0, 0), 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, f);
    idle(1);

    // Randomized traffic on a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, NR'($urandom),
            pk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 199) != 0, 1'b1, f);
    end
    idle(LD + 1);

    // Drive stall_cycles into saturation
    n = 0;
    extra = 0;
    while (extra < 300 && n < 100000) begin
      drive(1'b1, 3'b001, pk(20, 0, 0), 1'b1, 20, 1'b1, 1'b0, 1'b1,
            m_sc >= 16'hFF00, f);
      if (m_sc == 16'hFFFF) extra++;
      n++;
    end
    idle(LD + 2);

    @(negedge clk);
    #4;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_hazard_scoreboard.md
Name: reg_hazard_scoreboard

Overview:
- Parametrised ID-stage register scoreboard. Takes decoded read/write register addresses from decode and tracks pending destination writes with per-register countdown counters.
- Produces per-read-port hazard flags, a pipeline stall, an issue-accept strobe, and occupancy/stall statistics.
- Sits between decode and the ID/EX pipeline register. Generalises read/write register generation to N read ports, configurable latencies and RAW/WAW tracking.

Parameters:
- REG_ADDR_WIDTH, 5: register address width; tracked registers = 2**REG_ADDR_WIDTH.
- NUM_READ, 2: number of source-operand read ports.
- CNT_WIDTH, 3: countdown counter width per register.
- ALU_LATENCY, 1: cycles from issue until an ALU result is written back; must be < 2**CNT_WIDTH.
- LOAD_LATENCY, 3: cycles from issue until a load result is written back; must be < 2**CNT_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decoded instruction present in ID.
- rd_en  in  NUM_READ  read enable per source port.
- rd_addr  in  NUM_READ*REG_ADDR_WIDTH  source addresses; port i = bits [i*W +: W].
- wr_en  in  1  instruction writes a destination register.
- wr_addr  in  REG_ADDR_WIDTH  destination address (31 for JAL).
- wr_is_load  in  1  destination produced by a load.
- flush  in  1  squash in-flight work (branch mispredict / exception).
- hazard  out  NUM_READ  combinational: port i blocked.
- stall  out  1  combinational: OR of hazard, gated by issue_valid.
- issue_fire  out  1  combinational: issue_valid & ~stall & ~flush.
- busy_count  out  REG_ADDR_WIDTH+1  registered: count of registers with nonzero counter.
- stall_cycles  out  16  registered: saturating count of cycles with stall=1.

Behaviour:
- Reset (rst=0, asynchronous): all counters=0, busy_count=0, stall_cycles=0. Combinational outputs then evaluate to hazard=0 and stall=0.
- Register 0 is never tracked:
  - its counter is held at 0;
  - a read of address 0 never raises hazard;
  - a write to address 0 is ignored.
- Per-cycle counter update for every register r:
  - base = cnt[r]-1 if cnt[r]!=0, else 0.
  - If issue_fire & wr_en & wr_addr==r & r!=0: L = LOAD_LATENCY if wr_is_load, else ALU_LATENCY. cnt[r] <= max(base, L). This resolves WAW so a later short-latency write never shortens an older long one.
  - Otherwise cnt[r] <= base.
- Hazard for port i: rd_en[i] & addr_i!=0 & cnt[addr_i] >= THRESH. THRESH is set by the optional feature.
- A single instruction reading and writing the same register (e.g. addiu $t0,$t0,1) evaluates hazard against the pre-update counter. Its own write never stalls it.
- stall = issue_valid & |hazard.
- flush (synchronous, highest priority):
  - all counters <= 0 on the next edge;
  - issue_fire forced 0 that cycle;
  - busy_count <= 0.
  - stall_cycles is not cleared.
- busy_count is the population count of next-state counters with nonzero value, registered (one-cycle latency vs. counter state).
- stall_cycles increments on each cycle stall=1. It holds at 16'hFFFF (no wrap).
- No output depends combinationally on flush except issue_fire.

Optional Feature:
- Macro: SCOREBOARD_FWD_EN.
- Defined: EX/MEM forwarding exists; THRESH = 2. A value whose counter is 1 is bypassable, so dependent ALU ops never stall at ALU_LATENCY=1, and load-use stalls LOAD_LATENCY-1 cycles.
- Undefined: no forwarding; THRESH = 1. Any nonzero counter stalls, so a dependent instruction waits until write-back completes.

Test Plan:
- Reset: rst=0 mid-run with counters loaded → next sample stall=0, busy_count=0, stall_cycles=0. After rst=1, a read of a previously busy register shows hazard=0.
- ALU RAW, FWD_EN defined: issue write $8 (ALU), next cycle read $8 → stall=0, issue_fire=1. FWD_EN undefined: stall=1 for exactly 1 cycle.
- Load-use, FWD_EN defined, LOAD_LATENCY=3: issue load $9, next cycle read $9 on port 1 → hazard=2'b10 for 2 cycles, then issue_fire=1. stall_cycles=2.
- WAW and $0: load $10 then ALU write $10 the next cycle → cnt[10] stays 2, not reset to 1. Read/write of $0 → hazard=0, busy_count unchanged.
- Flush: three registers busy (busy_count=3), flush=1 with issue_valid=1 → issue_fire=0. Next cycle all hazard=0, busy_count=0, stall_cycles retained.
- Saturation / params: NUM_READ=3 with all ports on a busy register → hazard=3'b111. Force 70000 stall cycles → stall_cycles=16'hFFFF.
